// File: rtl/reg_file_sb.sv
// Parametrised register file with per-register busy scoreboard.
// Decode side reads operands and marks multi-cycle destinations busy; writeback side
// writes results and clears the busy mark. All outputs are registered.
module reg_file_sb #(
  parameter int unsigned WORDSIZE  = 32,
  parameter int unsigned BLOCKSIZE = 32,
  parameter int unsigned ADDRSIZE  = $clog2(BLOCKSIZE),
  parameter int unsigned NREAD     = 2,
  parameter bit          BYPASS    = 1'b1,
  parameter bit          ZERO_REG  = 1'b1
) (
  input  logic                        CLK,
  input  logic                        RST,
  // writeback
  input  logic                        WE,
  input  logic [ADDRSIZE-1:0]         AW,
  input  logic [WORDSIZE-1:0]         D,
  // operand read ports
  input  logic [NREAD*ADDRSIZE-1:0]   RA,
  output logic [NREAD*WORDSIZE-1:0]   RD,
  output logic [NREAD-1:0]            RBUSY,
  // scoreboard
  input  logic                        SET_BUSY,
  input  logic [ADDRSIZE-1:0]         SB_ADDR,
  output logic [BLOCKSIZE-1:0]        BUSY_VEC,
  // debug read port
  input  logic [ADDRSIZE-1:0]         DBR,
  output logic [WORDSIZE-1:0]         DBO
);

  // Address lies inside the implemented register range (matters when BLOCKSIZE is not 2^n).
  function automatic logic in_range(input logic [ADDRSIZE-1:0] addr);
    return (32'(addr) < BLOCKSIZE);
  endfunction

  // Register that can hold state: in range and not the hardwired zero register.
  function automatic logic is_real_reg(input logic [ADDRSIZE-1:0] addr);
    return in_range(addr) && !(ZERO_REG && (addr == '0));
  endfunction

  logic [WORDSIZE-1:0]  mem_q [BLOCKSIZE];
  logic [WORDSIZE-1:0]  mem_d [BLOCKSIZE];
  logic [BLOCKSIZE-1:0] busy_q, busy_d;
  logic [WORDSIZE-1:0]  dbo_q, dbo_d;
  logic                 wr_en;
  logic                 set_en;

  // Qualify write and busy-set requests against zero register and address range.
  always_comb begin
    wr_en  = WE && is_real_reg(AW);
    set_en = SET_BUSY && is_real_reg(SB_ADDR);
  end

  // Storage next state.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[AW] = D;
    end
  end

  // Scoreboard next state: clear on writeback first, then set on issue so a new issue wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[AW] = 1'b0;
    end
    if (set_en) begin
      busy_d[SB_ADDR] = 1'b1;
    end
  end

  // Debug read never sees the same-edge write.
  always_comb begin
    dbo_d = '0;
    if (in_range(DBR)) begin
      dbo_d = mem_q[DBR];
    end
  end

  // Storage, scoreboard and debug output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < int'(BLOCKSIZE); r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
      dbo_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      dbo_q  <= dbo_d;
    end
  end

  for (genvar g = 0; g < int'(NREAD); g++) begin : g_rd_port
    logic [ADDRSIZE-1:0] ra;
    logic [WORDSIZE-1:0] rd_q, rd_d;
    logic                rbusy_q, rbusy_d;

    assign ra = RA[g*ADDRSIZE +: ADDRSIZE];

    // Operand select; busy follows the next-state scoreboard so it lines up with bypassed data.
    always_comb begin
      rd_d    = '0;
      rbusy_d = 1'b0;
      if (is_real_reg(ra)) begin
        if (BYPASS && wr_en && (AW == ra)) begin
          rd_d = D;
        end else begin
          rd_d = mem_q[ra];
        end
        rbusy_d = busy_d[ra];
      end
    end

    // Per-port output registers.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        rd_q    <= '0;
        rbusy_q <= 1'b0;
      end else begin
        rd_q    <= rd_d;
        rbusy_q <= rbusy_d;
      end
    end

    assign RD[g*WORDSIZE +: WORDSIZE] = rd_q;
    assign RBUSY[g]                   = rbusy_q;
  end

  assign BUSY_VEC = busy_q;
  assign DBO      = dbo_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench: two builds (bypass+zero-reg, 32 regs) and (no bypass, no zero-reg, 24 regs)
// share stimulus; a reference model pushes expected outputs, a monitor pops and compares.
module tb_reg_file_sb;

  typedef struct packed {
    logic [95:0] rd;
    logic [2:0]  rb;
    logic [31:0] bv;
    logic [31:0] dbo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we;
  logic [4:0]  aw;
  logic [31:0] d;
  logic [14:0] ra;
  logic        set_busy;
  logic [4:0]  sb_addr;
  logic [4:0]  dbr;

  logic [95:0] rd_a, rd_b;
  logic [2:0]  rbusy_a, rbusy_b;
  logic [31:0] bv_a;
  logic [23:0] bv_b;
  logic [31:0] dbo_a, dbo_b;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t exp_a_q[$];
  exp_t exp_b_q[$];

  // model state per build: index 0 = build A, 1 = build B
  logic [31:0] m_mem  [2][32];
  logic        m_busy [2][32];

  reg_file_sb #(.NREAD(3)) dut_a (
    .CLK(clk), .RST(rst), .WE(we), .AW(aw), .D(d), .RA(ra), .RD(rd_a), .RBUSY(rbusy_a),
    .SET_BUSY(set_busy), .SB_ADDR(sb_addr), .BUSY_VEC(bv_a), .DBR(dbr), .DBO(dbo_a)
  );

  reg_file_sb #(.BLOCKSIZE(24), .NREAD(3), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .WE(we), .AW(aw), .D(d), .RA(ra), .RD(rd_b), .RBUSY(rbusy_b),
    .SET_BUSY(set_busy), .SB_ADDR(sb_addr), .BUSY_VEC(bv_b), .DBR(dbr), .DBO(dbo_b)
  );

  always #5 clk = ~clk;

  function automatic int nregs(input int c);
    return (c == 0) ? 32 : 24;
  endfunction

  function automatic logic holds_state(input int c, input int a);
    return (a < nregs(c)) && !((c == 0) && (a == 0));
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic reset_model();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 32; r++) begin
        m_mem[c][r]  = '0;
        m_busy[c][r] = 1'b0;
      end
  endtask

  // Reference behaviour for one clock edge of build c, using the current inputs.
  task automatic model_step(input int c, output exp_t e);
    logic nb [32];
    logic wr;
    int   a;
    wr = we && holds_state(c, int'(aw));
    for (int r = 0; r < 32; r++) nb[r] = m_busy[c][r];
    if (wr) nb[aw] = 1'b0;
    if (set_busy && holds_state(c, int'(sb_addr))) nb[sb_addr] = 1'b1;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      a = int'(ra[i*5 +: 5]);
      if (holds_state(c, a)) begin
        e.rd[i*32 +: 32] = ((c == 0) && wr && (int'(aw) == a)) ? d : m_mem[c][a];
        e.rb[i]          = nb[a];
      end
    end
    e.dbo = (int'(dbr) < nregs(c)) ? m_mem[c][dbr] : 32'h0;
    if (wr) m_mem[c][aw] = d;
    for (int r = 0; r < 32; r++) begin
      m_busy[c][r] = nb[r];
      if (r < nregs(c)) e.bv[r] = nb[r];
    end
  endtask

  // Drive one cycle of stimulus, predict, then hand the prediction to the monitor at the edge.
  task automatic issue(input logic i_we, input logic [4:0] i_aw, input logic [31:0] i_d,
                       input logic [4:0] i_ra0, input logic [4:0] i_ra1,
                       input logic [4:0] i_ra2, input logic i_set, input logic [4:0] i_sb,
                       input logic [4:0] i_dbr);
    exp_t ea, eb;
    we = i_we; aw = i_aw; d = i_d; ra = {i_ra2, i_ra1, i_ra0};
    set_busy = i_set; sb_addr = i_sb; dbr = i_dbr;
    model_step(0, ea);
    model_step(1, eb);
    @(posedge clk);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".A.rd"}, rd_a, '0);
    check({tag, ".A.rbusy"}, {93'b0, rbusy_a}, '0);
    check({tag, ".A.busy_vec"}, {64'b0, bv_a}, '0);
    check({tag, ".A.dbo"}, {64'b0, dbo_a}, '0);
    check({tag, ".B.rd"}, rd_b, '0);
    check({tag, ".B.rbusy"}, {93'b0, rbusy_b}, '0);
    check({tag, ".B.busy_vec"}, {72'b0, bv_b}, '0);
    check({tag, ".B.dbo"}, {64'b0, dbo_b}, '0);
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  // Monitor: every edge that had stimulus has a registered response visible by the falling edge.
  exp_t mon_a, mon_b;
  always @(negedge clk) begin
    if (exp_a_q.size() != 0 && exp_b_q.size() != 0) begin
      mon_a = exp_a_q.pop_front();
      mon_b = exp_b_q.pop_front();
      check("A.rd", rd_a, mon_a.rd);
      check("A.rbusy", {93'b0, rbusy_a}, {93'b0, mon_a.rb});
      check("A.busy_vec", {64'b0, bv_a}, {64'b0, mon_a.bv});
      check("A.dbo", {64'b0, dbo_a}, {64'b0, mon_a.dbo});
      check("B.rd", rd_b, mon_b.rd);
      check("B.rbusy", {93'b0, rbusy_b}, {93'b0, mon_b.rb});
      check("B.busy_vec", {72'b0, bv_b}, {64'b0, mon_b.bv});
      check("B.dbo", {64'b0, dbo_b}, {64'b0, mon_b.dbo});
    end
  end

  initial begin
    we = 0; aw = 0; d = 0; ra = 0; set_busy = 0; sb_addr = 0; dbr = 0;
    reset_model();
    rst = 1'b1;
    #1;
    check_all_zero("por");
    @(negedge clk);
    rst = 1'b0;

    // write/read and zero register
    issue(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 5, 0, 0, 0, 0, 5);
    issue(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // bypass collision with debug read
    issue(1, 7, 32'h11, 0, 0, 0, 0, 0, 0);
    issue(1, 7, 32'hA5A5A5A5, 7, 0, 0, 0, 0, 7);
    // scoreboard set, observe, clear
    issue(0, 0, 0, 0, 0, 0, 1, 3, 0);
    issue(0, 0, 0, 3, 0, 0, 0, 0, 0);
    issue(1, 3, 32'h33, 3, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 3, 3, 0, 0, 0, 3);
    // set and clear on the same edge, set on register 0
    issue(0, 0, 0, 0, 0, 0, 1, 9, 0);
    issue(1, 9, 32'h99, 9, 0, 0, 1, 9, 9);
    issue(0, 0, 0, 9, 0, 0, 1, 0, 9);
    // multi-port read with a busy register
    issue(1, 2, 32'h22, 0, 0, 0, 0, 0, 0);
    issue(1, 4, 32'h44, 0, 0, 0, 1, 4, 0);
    issue(0, 0, 0, 2, 2, 4, 0, 0, 4);
    // out-of-range for the 24-entry build
    issue(1, 30, 32'hF00D, 30, 0, 0, 1, 30, 30);
    issue(0, 0, 0, 30, 30, 30, 0, 0, 30);

    // asynchronous reset mid-operation, with a write and set pending on the edge
    @(negedge clk);
    #1;
    we = 1; aw = 5; d = 32'hFF; set_busy = 1; sb_addr = 5; ra = {5'd5, 5'd5, 5'd5};
    rst = 1'b1;
    #1;
    check_all_zero("rst");
    @(posedge clk);
    #1;
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    issue(0, 0, 0, 5, 5, 5, 0, 0, 5);

    for (int n = 0; n < 600; n++) begin
      issue(1'($urandom_range(0, 1)), rand_addr(), $urandom(), rand_addr(), rand_addr(),
            rand_addr(), 1'($urandom_range(0, 2) == 0), rand_addr(), rand_addr());
    end
    we = 0; set_busy = 0;
    @(negedge clk);
    #1;
    check("drain", 96'(exp_a_q.size() + exp_b_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
